// File: rtl/avr_pkg.sv
// Shared AVR write-back types: entry layout, sequencer states and byte-address helpers.
// Combinational helpers only; no latency or flow control.
package avr_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int BYTE_W     = 8;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic                  word;
      logic [2*BYTE_W-1:0]   data;
   } wb_entry_t;

   typedef enum logic [1:0] {
      WB_IDLE = 2'd0,
      WB_LO   = 2'd1,
      WB_HI   = 2'd2
   } wb_state_t;

   // Pair writes always target an even/odd register pair regardless of addr[0].
   function automatic logic [REG_ADDR_W-1:0] lo_addr(input logic [REG_ADDR_W-1:0] a,
                                                    input logic word);
      return word ? (a & ~REG_ADDR_W'(1)) : a;
   endfunction

   function automatic logic [REG_ADDR_W-1:0] hi_addr(input logic [REG_ADDR_W-1:0] a);
      return a | REG_ADDR_W'(1);
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// Write-back request FIFO with per-slot visibility for hazard comparison.
// Push result visible one cycle later; push ignored when full, pop ignored when empty.
module wb_fifo
   import avr_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    push_i,
   input  wb_entry_t               push_dat_i,
   input  logic                    pop_i,
   output logic                    full_o,
   output logic                    empty_o,
   output logic [$clog2(DEPTH):0]  count_o,
   output wb_entry_t               head_o,
   output logic [DEPTH-1:0]        ent_vld_o,
   output wb_entry_t [DEPTH-1:0]   ent_dat_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0]          wr_ptr_q;
   logic [AW-1:0]          rd_ptr_q;
   logic [AW:0]            count_q;
   wb_entry_t [DEPTH-1:0]  mem_q;
   logic [DEPTH-1:0]       vld_q;
   logic                   do_push;
   logic                   do_pop;

   assign full_o    = (count_q == (AW+1)'(DEPTH));
   assign empty_o   = (count_q == '0);
   assign count_o   = count_q;
   assign head_o    = mem_q[rd_ptr_q];
   assign ent_vld_o = vld_q;
   assign ent_dat_o = mem_q;
   assign do_push   = push_i && !full_o;
   assign do_pop    = pop_i && !empty_o;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         mem_q    <= '0;
         vld_q    <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
            vld_q[wr_ptr_q] <= 1'b1;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            vld_q[rd_ptr_q] <= 1'b0;
            rd_ptr_q        <= rd_ptr_q + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/register_writeback.sv
// Serialises byte/pair write-back results onto the single register-file write port.
// rf_we one cycle after acceptance; wb_ready is FIFO-not-full from the registered count.
module register_writeback
   import avr_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wb_valid,
   output logic        wb_ready,
   input  logic [4:0]  wb_addr,
   input  logic        wb_word,
   input  logic [15:0] wb_data,
   output logic        rf_we,
   output logic [4:0]  rf_add,
   output logic [7:0]  rf_din,
   output logic        rf_busy,
   input  logic [4:0]  chk_addr,
   output logic        hazard,
   output logic        empty
);

   wb_state_t                state_q, state_d;
   wb_entry_t                cur_q, cur_d;
   logic                     from_fifo_q, from_fifo_d;
   logic                     rf_we_q, rf_we_d;
   logic [REG_ADDR_W-1:0]    rf_add_q, rf_add_d;
   logic [BYTE_W-1:0]        rf_din_q, rf_din_d;

   logic                     push, pop, accept;
   logic                     fifo_full, fifo_empty;
   logic [$clog2(DEPTH):0]   fifo_count;
   wb_entry_t                head, req;
   logic [DEPTH-1:0]         ent_vld;
   wb_entry_t [DEPTH-1:0]    ent_dat;

   assign req      = {wb_addr, wb_word, wb_data};
   assign wb_ready = !fifo_full;
   assign accept   = wb_valid && wb_ready;

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst_n      (reset),
      .push_i     (push),
      .push_dat_i (req),
      .pop_i      (pop),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .count_o    (fifo_count),
      .head_o     (head),
      .ent_vld_o  (ent_vld),
      .ent_dat_o  (ent_dat)
   );

   // A pair taken from the FIFO stays queued until its high byte loads, so
   // both of its addresses remain visible to the hazard check meanwhile.
   always_comb begin
      state_d     = state_q;
      cur_d       = cur_q;
      from_fifo_d = from_fifo_q;
      rf_we_d     = 1'b0;
      rf_add_d    = rf_add_q;
      rf_din_d    = rf_din_q;
      push        = 1'b0;
      pop         = 1'b0;
      if (state_q == WB_LO && cur_q.word) begin
         state_d  = WB_HI;
         rf_we_d  = 1'b1;
         rf_add_d = hi_addr(cur_q.addr);
         rf_din_d = cur_q.data[15:8];
         pop      = from_fifo_q;
         push     = accept;
      end else if (!fifo_empty) begin
         state_d     = WB_LO;
         cur_d       = head;
         from_fifo_d = 1'b1;
         rf_we_d     = 1'b1;
         rf_add_d    = lo_addr(head.addr, head.word);
         rf_din_d    = head.data[7:0];
         pop         = !head.word;
         push        = accept;
      end else if (accept) begin
         state_d     = WB_LO;
         cur_d       = req;
         from_fifo_d = 1'b0;
         rf_we_d     = 1'b1;
         rf_add_d    = lo_addr(req.addr, req.word);
         rf_din_d    = req.data[7:0];
      end else begin
         state_d = WB_IDLE;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= WB_IDLE;
         cur_q       <= '0;
         from_fifo_q <= 1'b0;
         rf_we_q     <= 1'b0;
         rf_add_q    <= '0;
         rf_din_q    <= '0;
      end else begin
         state_q     <= state_d;
         cur_q       <= cur_d;
         from_fifo_q <= from_fifo_d;
         rf_we_q     <= rf_we_d;
         rf_add_q    <= rf_add_d;
         rf_din_q    <= rf_din_d;
      end
   end

   always_comb begin
      hazard = 1'b0;
      if (rf_we_q && (chk_addr == rf_add_q ||
                      (state_q == WB_LO && cur_q.word && chk_addr == hi_addr(cur_q.addr))))
         hazard = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_vld[i] && (chk_addr == lo_addr(ent_dat[i].addr, ent_dat[i].word) ||
                            (ent_dat[i].word && chk_addr == hi_addr(ent_dat[i].addr))))
            hazard = 1'b1;
      end
   end

   assign rf_we   = rf_we_q;
   assign rf_busy = rf_we_q;
   assign rf_add  = rf_add_q;
   assign rf_din  = rf_din_q;
   assign empty   = (fifo_count == '0) && (state_q == WB_IDLE) && !rf_we_q;

endmodule
